// File: rtl/lsu_access_ctrl.sv
// Load/store access controller in front of a word-organised data RAM.
// Optional macro LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into byte accesses.
module lsu_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [31:0]       ram_w_data,
  output logic [1:0]        ram_write_mode,
  output logic [1:0]        ram_read_mode,
  output logic              ram_read_signed,
  input  logic [31:0]       ram_r_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       result_q;

  logic [ADDR_W-1:0] hold_addr_q;
  logic [31:0]       hold_wdata_q;
  logic [1:0]        hold_mode_q;
  logic              hold_signed_q;

  logic              is_illegal;
  logic              is_split;
  logic              accept_err;
  logic              split_active;

  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [1:0]        acc_mode;
  logic              acc_signed;
  logic              acc_last;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q;
  logic [1:0]        k_q;
  logic [1:0]        last_q;
`endif

  // Classify the incoming request: only accesses that cross a word boundary split.
  always_comb begin
    is_illegal = (req_size == 2'd3);
    is_split   = ((req_size == 2'd1) && (req_addr[1:0] == 2'd3)) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));
`ifdef LSU_MISALIGN_SPLIT_EN
    accept_err = is_illegal;
`else
    accept_err = is_illegal | is_split;
`endif
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign split_active = split_q;
`else
  assign split_active = 1'b0;
`endif

  // Address, data and mode presented to the RAM for the current access cycle.
  always_comb begin
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_mode   = size_q;
    acc_signed = signed_q;
    acc_last   = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
    if (split_q) begin
      acc_addr   = addr_q + ADDR_W'(k_q);
      acc_wdata  = {24'b0, wdata_q[8*k_q +: 8]};
      acc_mode   = 2'd0;
      acc_signed = 1'b0;
      acc_last   = (k_q == last_q);
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = accept_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (acc_last) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch, result assembly and hold copies of the RAM-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      size_q        <= 2'd0;
      signed_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      err_q         <= 1'b0;
      result_q      <= 32'd0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= 32'd0;
      hold_mode_q   <= 2'd0;
      hold_signed_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
      k_q           <= 2'd0;
      last_q        <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= accept_err;
            result_q <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q  <= is_split & ~is_illegal;
            k_q      <= 2'd0;
            last_q   <= (req_size == 2'd1) ? 2'd1 : 2'd3;
`endif
          end
        end
        ACCESS: begin
          hold_addr_q   <= acc_addr;
          hold_wdata_q  <= acc_wdata;
          hold_mode_q   <= acc_mode;
          hold_signed_q <= acc_signed;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            result_q[8*k_q +: 8] <= ram_r_data[7:0];
            k_q                  <= k_q + 2'd1;
          end else begin
            result_q <= ram_r_data;
          end
`else
          result_q <= ram_r_data;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (state == ACCESS) begin
      ram_r_addr      = acc_addr;
      ram_w_data      = acc_wdata;
      ram_write_mode  = acc_mode;
      ram_read_mode   = acc_mode;
      ram_read_signed = acc_signed;
    end else begin
      ram_r_addr      = hold_addr_q;
      ram_w_data      = hold_wdata_q;
      ram_write_mode  = hold_mode_q;
      ram_read_mode   = hold_mode_q;
      ram_read_signed = hold_signed_q;
    end
  end

  assign ram_w_addr = ram_r_addr;
  // Gated by rst_n directly so a reset landing mid-store cannot commit a write.
  assign ram_we     = (state == ACCESS) & we_q & rst_n;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) & err_q;

  // Split signed half loads are assembled from unsigned bytes, so extend here.
  always_comb begin
    resp_rdata = 32'd0;
    if ((state == RESP) && !we_q && !err_q) begin
      if (split_active && (size_q == 2'd1) && signed_q) begin
        resp_rdata = {{16{result_q[15]}}, result_q[15:0]};
      end else begin
        resp_rdata = result_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed bench for lsu_access_ctrl with a byte-array RAM model sampling on negedge.
// Split-access vectors are active when LSU_MISALIGN_SPLIT_EN is defined.
module tb_lsu_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_we;
  logic [31:0] ram_r_addr;
  logic [31:0] ram_w_addr;
  logic [31:0] ram_w_data;
  logic [1:0]  ram_write_mode;
  logic [1:0]  ram_read_mode;
  logic        ram_read_signed;
  logic [31:0] ram_r_data;

  int checks = 0;
  int errors = 0;

  bit [7:0]    mem [0:4095];
  int          write_count = 0;
  int          resp_count  = 0;
  logic [31:0] write_log [$];

  lsu_access_ctrl #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .ram_we          (ram_we),
    .ram_r_addr      (ram_r_addr),
    .ram_w_addr      (ram_w_addr),
    .ram_w_data      (ram_w_data),
    .ram_write_mode  (ram_write_mode),
    .ram_read_mode   (ram_read_mode),
    .ram_read_signed (ram_read_signed),
    .ram_r_data      (ram_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] readRam(logic [31:0] a, logic [1:0] mode, logic sgn);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[11:0]];
    b1 = mem[a[11:0] + 12'd1];
    b2 = mem[a[11:0] + 12'd2];
    b3 = mem[a[11:0] + 12'd3];
    case (mode)
      2'd0:    return sgn ? {{24{b0[7]}}, b0} : {24'b0, b0};
      2'd1:    return sgn ? {{16{b1[7]}}, b1, b0} : {16'b0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // RAM model: writes and read data are both sampled on the falling edge.
  always @(negedge clk) begin
    if (ram_we) begin
      write_count <= write_count + 1;
      write_log.push_back(ram_w_addr);
      mem[ram_w_addr[11:0]] <= ram_w_data[7:0];
      if (ram_write_mode != 2'd0) begin
        mem[ram_w_addr[11:0] + 12'd1] <= ram_w_data[15:8];
      end
      if (ram_write_mode == 2'd2) begin
        mem[ram_w_addr[11:0] + 12'd2] <= ram_w_data[23:16];
        mem[ram_w_addr[11:0] + 12'd3] <= ram_w_data[31:24];
      end
    end
    if (resp_valid) begin
      resp_count <= resp_count + 1;
    end
    ram_r_data <= readRam(ram_r_addr, ram_read_mode, ram_read_signed);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Issue one request, wait for its response; lat counts cycles after the accept edge.
  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat,
                               output int writes);
    int start_writes;
    int guard;
    @(negedge clk);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    start_writes = write_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      checkOutput({tag, "_timeout"}, 32'(resp_valid), 32'd1);
    end
    rdata  = resp_rdata;
    err    = resp_err;
    writes = write_count - start_writes;
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    int          log_start;
    int          low_cycles;
    int          exp_lat;
    int          guard;
    int          resp_before;
    int          writes_before;
    int          reset_cycle;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    rst_n = 1'b1;

    applyStimulus("st_word", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, rdata, err, lat, writes);
    checkOutput("st_word_lat", 32'(lat), 32'd2);
    checkOutput("st_word_err", 32'(err), 32'd0);
    checkOutput("st_word_rdata", rdata, 32'd0);
    checkOutput("st_word_writes", 32'(writes), 32'd1);

    applyStimulus("ld_word", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rdata, err, lat, writes);
    checkOutput("ld_word_rdata", rdata, 32'hDEADBEEF);
    checkOutput("ld_word_lat", 32'(lat), 32'd2);
    checkOutput("ld_word_writes", 32'(writes), 32'd0);

    applyStimulus("ld_byte_s", 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, rdata, err, lat, writes);
    checkOutput("ld_byte_s_rdata", rdata, 32'hFFFFFFBE);
    applyStimulus("ld_byte_u", 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, rdata, err, lat, writes);
    checkOutput("ld_byte_u_rdata", rdata, 32'h000000BE);

    applyStimulus("ld_half_s0", 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, rdata, err, lat, writes);
    checkOutput("ld_half_s0_rdata", rdata, 32'hFFFFBEEF);
    applyStimulus("ld_half_u2", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rdata, err, lat, writes);
    checkOutput("ld_half_u2_rdata", rdata, 32'h0000DEAD);
    checkOutput("ld_half_u2_lat", 32'(lat), 32'd2);

    applyStimulus("st_b303", 1'b1, 2'd0, 1'b0, 32'h303, 32'h00000080, rdata, err, lat, writes);
    checkOutput("st_b303_writes", 32'(writes), 32'd1);
    applyStimulus("st_b304", 1'b1, 2'd0, 1'b0, 32'h304, 32'h00000081, rdata, err, lat, writes);
    checkOutput("st_b304_lat", 32'(lat), 32'd2);

    applyStimulus("ld_half_x", 1'b0, 2'd1, 1'b1, 32'h303, 32'h0, rdata, err, lat, writes);
`ifdef LSU_MISALIGN_SPLIT_EN
    checkOutput("ld_half_x_rdata", rdata, 32'hFFFF8180);
    checkOutput("ld_half_x_err", 32'(err), 32'd0);
    checkOutput("ld_half_x_lat", 32'(lat), 32'd3);

    log_start = write_log.size();
    applyStimulus("st_word_x", 1'b1, 2'd2, 1'b0, 32'h203, 32'h11223344, rdata, err, lat, writes);
    checkOutput("st_word_x_writes", 32'(writes), 32'd4);
    checkOutput("st_word_x_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (log_start + i < write_log.size()) begin
        checkOutput($sformatf("st_word_x_addr%0d", i), write_log[log_start + i], 32'h203 + 32'(i));
      end else begin
        checkOutput($sformatf("st_word_x_addr%0d", i), 32'hFFFFFFFF, 32'h203 + 32'(i));
      end
    end
    applyStimulus("ld_word_x", 1'b0, 2'd2, 1'b0, 32'h203, 32'h0, rdata, err, lat, writes);
    checkOutput("ld_word_x_rdata", rdata, 32'h11223344);
    checkOutput("ld_word_x_lat", 32'(lat), 32'd5);
`else
    checkOutput("ld_half_x_err", 32'(err), 32'd1);
    checkOutput("ld_half_x_rdata", rdata, 32'd0);
    checkOutput("ld_half_x_lat", 32'(lat), 32'd1);

    applyStimulus("st_word_x", 1'b1, 2'd2, 1'b0, 32'h203, 32'h11223344, rdata, err, lat, writes);
    checkOutput("st_word_x_err", 32'(err), 32'd1);
    checkOutput("st_word_x_writes", 32'(writes), 32'd0);
    checkOutput("st_word_x_lat", 32'(lat), 32'd1);
    checkOutput("st_word_x_mem", 32'(mem[12'h203]), 32'd0);
`endif

    applyStimulus("illegal", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rdata, err, lat, writes);
    checkOutput("illegal_err", 32'(err), 32'd1);
    checkOutput("illegal_rdata", rdata, 32'd0);
    checkOutput("illegal_lat", 32'(lat), 32'd1);
    checkOutput("illegal_writes", 32'(writes), 32'd0);

    // Held request: req_valid stays high across the whole transaction.
    @(negedge clk);
    req_we     = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_addr   = 32'h203;
    exp_lat    = 5;
`else
    req_addr   = 32'h100;
    exp_lat    = 2;
`endif
    req_valid  = 1'b1;
    @(posedge clk);
    low_cycles = 0;
    guard      = 0;
    while (guard < 20) begin
      @(negedge clk);
      guard++;
      if (!req_ready) low_cycles++;
      if (resp_valid) break;
    end
    checkOutput("hold_resp_seen", 32'(resp_valid), 32'd1);
    checkOutput("hold_ready_in_resp", 32'(req_ready), 32'd0);
    checkOutput("hold_low_cycles", 32'(low_cycles), 32'(exp_lat));
    @(negedge clk);
    checkOutput("hold_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);
    checkOutput("hold_reaccepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("hold_second_resp", 32'(resp_valid), 32'd1);
`ifdef LSU_MISALIGN_SPLIT_EN
    checkOutput("hold_second_rdata", resp_rdata, 32'h11223344);
`else
    checkOutput("hold_second_rdata", resp_rdata, 32'hDEADBEEF);
`endif

    // Reset during a store: no write in the reset cycle, no response afterwards.
    @(negedge clk);
    req_we     = 1'b1;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_wdata  = 32'hAABBCCDD;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_addr    = 32'h403;
    reset_cycle = 3;
`else
    req_addr    = 32'h400;
    reset_cycle = 1;
`endif
    req_valid     = 1'b1;
    writes_before = write_count;
    resp_before   = resp_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c < reset_cycle; c++) begin
      @(posedge clk);
    end
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_mid_ram_we", 32'(ram_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("rst_mid_no_resp", 32'(resp_count - resp_before), 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    checkOutput("rst_mid_writes", 32'(write_count - writes_before), 32'd2);
    checkOutput("rst_mid_b404", 32'(mem[12'h404]), 32'h000000CC);
    checkOutput("rst_mid_b405", 32'(mem[12'h405]), 32'd0);
`else
    checkOutput("rst_mid_writes", 32'(write_count - writes_before), 32'd0);
    checkOutput("rst_mid_b400", 32'(mem[12'h400]), 32'd0);
`endif

    applyStimulus("post_rst", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rdata, err, lat, writes);
    checkOutput("post_rst_rdata", rdata, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
